// File: rtl/unary_add_pkg.sv
// Shared constants and types for the serial unary adder.
//   OP_W   : per-operand count width (operands saturate at OP_MAX)
//   SUM_W  : width of the operand sum / emit counter
//   phase_e: read (accumulate) vs write (emit) phase encoding
package unary_add_pkg;
    localparam int OP_W  = 4;
    localparam int SUM_W = 5;
    localparam logic [OP_W-1:0] OP_MAX = 4'd15;

    typedef enum logic {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } phase_e;
endpackage

// File: rtl/unary_add_1_4_5_unary_sat_counter.sv
// Saturating up-counter for one unary operand stream.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low clear
//   en    : when low the count holds
//   inc   : count one more input pulse (dropped once at OP_MAX)
//   count : current operand count
module unary_sat_counter
    import unary_add_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            inc,
    output logic [OP_W-1:0] count
);
    logic [OP_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && inc && (count_q != OP_MAX))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/unary_add_1_4_5.sv
// Serial unary adder: counts ones on A and B during the read phase, then
// replays A+B as a train of consecutive ones on dout during the write phase.
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset, clears all state
//   en            : global enable, all state holds when low
//   read_or_write : 0 = accumulate, 1 = emit
//   A, B          : unary operand streams
//   dout          : registered unary sum stream
//   C             : registered carry, bit 4 of the current operand sum
module unary_add_1_4_5
    import unary_add_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic read_or_write,
    input  logic A,
    input  logic B,
    output logic dout,
    output logic C
);
    phase_e           phase;
    logic [OP_W-1:0]  cnt_a, cnt_b;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rem_q, rem_d;
    logic             mode_q, mode_d;
    logic             dout_q, dout_d;
    logic             c_q, c_d;

    assign phase = phase_e'(read_or_write);

    // Operands only accumulate in the read phase; A/B are ignored while emitting.
    unary_sat_counter u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inc   (A && (phase == PH_READ)),
        .count (cnt_a)
    );

    unary_sat_counter u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inc   (B && (phase == PH_READ)),
        .count (cnt_b)
    );

    // 15 + 15 = 30 fits in SUM_W bits, so no overflow handling is needed.
    assign sum = {1'b0, cnt_a} + {1'b0, cnt_b};

    always_comb begin
        rem_d  = rem_q;
        mode_d = mode_q;
        dout_d = dout_q;
        c_d    = c_q;
        if (en) begin
            mode_d = read_or_write;
            c_d    = sum[SUM_W-1];
            if (phase == PH_READ) begin
                // Also covers an aborted emission: remaining count is discarded.
                rem_d  = '0;
                dout_d = 1'b0;
            end else if (!mode_q) begin
                // First write edge only loads the emit count; ones start next edge.
                rem_d  = sum;
                dout_d = 1'b0;
            end else if (rem_q != '0) begin
                rem_d  = rem_q - 1'b1;
                dout_d = 1'b1;
            end else begin
                dout_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            mode_q <= 1'b0;
            dout_q <= 1'b0;
            c_q    <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
            c_q    <= c_d;
        end
    end

    assign dout = dout_q;
    assign C    = c_q;
endmodule

// File: tb/tb_unary_add_1_4_5.sv
module tb_unary_add_1_4_5;
    logic clk = 1'b0;
    logic rst_n, en, read_or_write, A, B;
    logic dout, C;

    int n_chk = 0;
    int n_err = 0;

    unary_add_1_4_5 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .read_or_write (read_or_write),
        .A             (A),
        .B             (B),
        .dout          (dout),
        .C             (C)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; read_or_write = 1'b0; A = 1'b0; B = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Read-phase feed: na cycles of A only, then nb cycles of B only.
    task automatic feed(input int na, input int nb);
        read_or_write = 1'b0;
        for (int i = 0; i < na; i++) begin A = 1'b1; B = 1'b0; step(); end
        for (int i = 0; i < nb; i++) begin A = 1'b0; B = 1'b1; step(); end
        A = 1'b0; B = 1'b0;
    endtask

    // Enter write phase and check: dout low on the load edge, C, then exactly
    // exp consecutive ones followed by zeros. A/B toggle to show they are ignored.
    task automatic emit(input string tag, input int exp, input int exp_c);
        int ones, shape;
        read_or_write = 1'b1;
        step();
        chk({tag, "_load_dout"}, dout, 0);
        chk({tag, "_carry"}, C, exp_c);
        ones = 0; shape = 0;
        for (int i = 0; i < 34; i++) begin
            A = i[0]; B = ~i[0];
            step();
            if (dout) ones++;
            if (dout !== (i < exp)) shape++;
        end
        A = 1'b0; B = 1'b0;
        chk({tag, "_ones"}, ones, exp);
        chk({tag, "_shape_err"}, shape, 0);
        read_or_write = 1'b0;
        step();
    endtask

    initial begin
        int ones, shape;
        rst_n = 1'b1; en = 1'b1; read_or_write = 1'b0; A = 1'b0; B = 1'b0;

        // Reset state and empty sum
        do_reset();
        chk("rst_dout", dout, 0);
        chk("rst_C", C, 0);
        emit("zero", 0, 0);

        // Saturation: 19 cycles of A=B=1 -> 15+15
        do_reset();
        read_or_write = 1'b0; A = 1'b1; B = 1'b1;
        for (int i = 0; i < 19; i++) step();
        A = 1'b0; B = 1'b0;
        chk("sat_read_dout", dout, 0);
        emit("sat", 30, 1);

        // Small sum
        do_reset();
        feed(3, 5);
        emit("small", 8, 0);

        // Carry boundaries
        do_reset();
        feed(15, 1);
        emit("c16", 16, 1);
        do_reset();
        feed(10, 5);
        emit("c15", 15, 0);

        // Accumulation resumes from held counts after a write phase: 15 + 3 more on B
        feed(0, 3);
        emit("resume", 18, 1);

        // Abort mid-emission, then re-emit
        do_reset();
        feed(10, 10);
        read_or_write = 1'b1;
        step();
        ones = 0;
        for (int i = 0; i < 5; i++) begin step(); if (dout) ones++; end
        chk("abort_pre_ones", ones, 5);
        read_or_write = 1'b0;
        step();
        chk("abort_dout", dout, 0);
        emit("reemit", 20, 1);

        // Enable gating in read phase
        do_reset();
        feed(2, 0);
        en = 1'b0; A = 1'b1; B = 1'b1;
        for (int i = 0; i < 5; i++) step();
        en = 1'b1; A = 1'b0; B = 1'b0;
        emit("en_read", 2, 0);

        // Enable gating mid-emission: train pauses and resumes
        do_reset();
        feed(6, 0);
        read_or_write = 1'b1;
        step();
        ones = 0;
        for (int i = 0; i < 3; i++) begin step(); if (dout) ones++; end
        chk("pause_pre_ones", ones, 3);
        en = 1'b0;
        shape = 0;
        for (int i = 0; i < 4; i++) begin step(); if (dout !== 1'b1) shape++; end
        chk("pause_frozen_err", shape, 0);
        en = 1'b1;
        ones = 0; shape = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (dout) ones++;
            if (dout !== (i < 3)) shape++;
        end
        chk("pause_post_ones", ones, 3);
        chk("pause_post_shape", shape, 0);

        // Reset mid-emission stops the train
        do_reset();
        feed(5, 5);
        read_or_write = 1'b1;
        step();
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_dout", dout, 0);
        chk("midrst_C", C, 0);
        ones = 0;
        for (int i = 0; i < 12; i++) begin step(); if (dout) ones++; end
        chk("midrst_ones", ones, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
